// File: rtl/bch_sched_pkg.sv
// Shared types and default sizing for the BCH decoder stage scheduler.
package bch_sched_pkg;

    localparam int FRAME_LEN_DEF = 1023;
    localparam int CNT_LEN_DEF   = 10;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_RUN  = 2'd1,
        K_HOLD = 2'd2
    } kes_state_t;

endpackage

// File: rtl/bch_stage_scheduler_if.sv
// Handshake bundle between the codeword source / decoder stages and the scheduler.
interface bch_stage_scheduler_if
    import bch_sched_pkg::*;
#(
    parameter int CNT_LEN = CNT_LEN_DEF
);
    logic               in_en;
    logic               in_frame_start;
    logic               out_in_ready;
    logic               out_syn_busy;
    logic [CNT_LEN-1:0] out_syn_cnt;
    logic               out_kes_start;
    logic               in_kes_done;
    logic               out_kes_busy;
    logic               out_chien_start;
    logic               out_chien_busy;
    logic [CNT_LEN-1:0] out_chien_cnt;
    logic               out_frame_done;
    logic [CNT_LEN-1:0] out_frame_cnt;
    logic               out_overrun;

    modport master (
        output in_en, in_frame_start, in_kes_done,
        input  out_in_ready, out_syn_busy, out_syn_cnt, out_kes_start,
               out_kes_busy, out_chien_start, out_chien_busy, out_chien_cnt,
               out_frame_done, out_frame_cnt, out_overrun
    );

    modport slave (
        input  in_en, in_frame_start, in_kes_done,
        output out_in_ready, out_syn_busy, out_syn_cnt, out_kes_start,
               out_kes_busy, out_chien_start, out_chien_busy, out_chien_cnt,
               out_frame_done, out_frame_cnt, out_overrun
    );

endinterface

// File: rtl/bch_stage_cnt.sv
// Fixed-length stage symbol counter: 0 = idle, 1..FRAME_LEN while a frame is held.
module bch_stage_cnt
    import bch_sched_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_LEN   = CNT_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic               advance,
    output logic [CNT_LEN-1:0] cnt,
    output logic               last,
    output logic               busy
);

    localparam logic [CNT_LEN-1:0] CNT_ONE  = CNT_LEN'(1);
    localparam logic [CNT_LEN-1:0] CNT_LAST = CNT_LEN'(FRAME_LEN);

    assign last = (cnt == CNT_LAST);
    assign busy = (cnt != '0);

    // At the last symbol the counter either hands off (reloading on a
    // back-to-back start) or stalls until the next stage frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (!busy) begin
                if (start) cnt <= CNT_ONE;
            end else if (last) begin
                if (advance) cnt <= start ? CNT_ONE : '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/bch_stage_scheduler.sv
// Sequences syndrome (S0), key-equation (S1) and Chien search (S2) stages of a BCH decoder.
module bch_stage_scheduler
    import bch_sched_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_LEN   = CNT_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  in_Arst_n,
    bch_stage_scheduler_if.slave  sif
);

    kes_state_t         kes_state;
    logic               kes_start_p1;
    logic               chien_start_p1;
    logic [CNT_LEN-1:0] frame_cnt;
    logic               overrun;

    logic [CNT_LEN-1:0] syn_cnt;
    logic [CNT_LEN-1:0] chien_cnt;
    logic               syn_last;
    logic               syn_busy;
    logic               chien_last;
    logic               chien_busy;

    logic               en;
    logic               kes_idle;
    logic               syn_handoff;
    logic               in_ready;
    logic               syn_accept;
    logic               chien_free;
    logic               kes_result;
    logic               chien_go;

    assign en          = sif.in_en;
    assign kes_idle    = (kes_state == K_IDLE);
    assign syn_handoff = syn_last & kes_idle;
    assign in_ready    = ~syn_busy | syn_handoff;
    assign syn_accept  = en & sif.in_frame_start & in_ready;
    // S2 completing this cycle counts as free, so a solved frame moves in without a bubble.
    assign chien_free  = ~chien_busy | chien_last;
    assign kes_result  = ((kes_state == K_RUN) & sif.in_kes_done) | (kes_state == K_HOLD);
    assign chien_go    = en & kes_result & chien_free;

    bch_stage_cnt #(.FRAME_LEN(FRAME_LEN), .CNT_LEN(CNT_LEN)) u_syn_cnt (
        .clk     (clk),
        .rst_n   (in_Arst_n),
        .en      (en),
        .start   (syn_accept),
        .advance (syn_handoff),
        .cnt     (syn_cnt),
        .last    (syn_last),
        .busy    (syn_busy)
    );

    bch_stage_cnt #(.FRAME_LEN(FRAME_LEN), .CNT_LEN(CNT_LEN)) u_chien_cnt (
        .clk     (clk),
        .rst_n   (in_Arst_n),
        .en      (en),
        .start   (chien_go),
        .advance (1'b1),
        .cnt     (chien_cnt),
        .last    (chien_last),
        .busy    (chien_busy)
    );

    // Stage boundary p0 -> p1: KES control and the registered start pulses.
    always_ff @(posedge clk or negedge in_Arst_n) begin
        if (!in_Arst_n) begin
            kes_state      <= K_IDLE;
            kes_start_p1   <= 1'b0;
            chien_start_p1 <= 1'b0;
        end else if (en) begin
            kes_start_p1   <= 1'b0;
            chien_start_p1 <= 1'b0;
            case (kes_state)
                K_IDLE: begin
                    if (syn_handoff) begin
                        kes_state    <= K_RUN;
                        kes_start_p1 <= 1'b1;
                    end
                end
                K_RUN: begin
                    if (sif.in_kes_done) begin
                        if (chien_free) begin
                            kes_state      <= K_IDLE;
                            chien_start_p1 <= 1'b1;
                        end else begin
                            kes_state <= K_HOLD;
                        end
                    end
                end
                K_HOLD: begin
                    if (chien_free) begin
                        kes_state      <= K_IDLE;
                        chien_start_p1 <= 1'b1;
                    end
                end
                default: kes_state <= K_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge in_Arst_n) begin
        if (!in_Arst_n) begin
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else if (en) begin
            if (chien_last) frame_cnt <= frame_cnt + CNT_LEN'(1);
            if (sif.in_frame_start && !in_ready) overrun <= 1'b1;
        end
    end

    // Pulses are held (not lost) while disabled and only masked at the output.
    assign sif.out_in_ready    = in_ready;
    assign sif.out_syn_busy    = syn_busy;
    assign sif.out_syn_cnt     = syn_cnt;
    assign sif.out_kes_start   = kes_start_p1 & en;
    assign sif.out_kes_busy    = ~kes_idle;
    assign sif.out_chien_start = chien_start_p1 & en;
    assign sif.out_chien_busy  = chien_busy;
    assign sif.out_chien_cnt   = chien_cnt;
    assign sif.out_frame_done  = chien_last & en;
    assign sif.out_frame_cnt   = frame_cnt;
    assign sif.out_overrun     = overrun;

endmodule
